// File: rtl/alu_pkg.sv
// alu_pkg: op codes, sequencer states, flag indices and op legality shared by the ALU sequencer.
package alu_pkg;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0110;
  localparam logic [3:0] OP_MUL = 4'b1001;
  localparam logic [3:0] OP_ASR = 4'b1101;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_RESP} state_t;
  function automatic logic is_legal_op(input logic [3:0] op);
    return op < 4'b1110;
  endfunction
endpackage

// File: rtl/shift_add_mul.sv
// shift_add_mul: iterative unsigned multiplier, one conditional shifted add per cycle after start.
module shift_add_mul #(
  parameter int WIDTH  = 32,
  parameter int CYCLES = WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_multiplicand,
  input  logic [WIDTH-1:0]   i_multiplier,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);
  localparam int CW = $clog2(CYCLES);
  logic               r_busy;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_product;
  // o_product already includes this cycle's add so the caller can capture it on the done edge
  always_comb begin
    o_product = r_mplier[0] ? r_product + ({{WIDTH{1'b0}}, r_mcand} << r_count) : r_product;
    o_done    = r_busy && (r_count == CW'(CYCLES - 1));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy    <= 1'b0;
      r_count   <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_product <= '0;
    end else if (i_start) begin
      r_busy    <= 1'b1;
      r_count   <= '0;
      r_mcand   <= i_multiplicand;
      r_mplier  <= i_multiplier;
      r_product <= '0;
    end else if (r_busy) begin
      r_product <= o_product;
      r_mplier  <= r_mplier >> 1;
      r_count   <= r_count + 1'b1;
      r_busy    <= !o_done;
    end
  end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: accumulator command sequencer around an external ALU, with in-house shift-add multiply.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_operand,
  input  logic             cmd_cin,
  input  logic             cmd_load,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_cout,
  input  logic             alu_negative,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err
);
  state_t               r_state, w_next;
  logic [WIDTH-1:0]     r_acc, r_operand;
  logic [3:0]           r_op, r_flags;
  logic                 r_cin, r_err;
  logic                 w_accept, w_direct, w_start, w_mul_done, w_hi;
  logic [2*WIDTH-1:0]   w_product;
  always_comb begin
    w_accept = (r_state == S_IDLE) && cmd_valid;
    w_direct = cmd_load || !is_legal_op(cmd_op);
    w_start  = w_accept && !w_direct && (cmd_op == OP_MUL);
    w_hi     = |w_product[2*WIDTH-1:WIDTH];
    w_next   = r_state;
    case (r_state)
      S_IDLE: if (cmd_valid) w_next = w_direct ? S_RESP : (cmd_op == OP_MUL) ? S_MUL : S_EXEC;
      S_EXEC: w_next = S_RESP;
      S_MUL:  if (w_mul_done) w_next = S_RESP;
      S_RESP: if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_operand <= '0;
      r_op      <= '0;
      r_cin     <= 1'b0;
      r_flags   <= '0;
      r_err     <= 1'b0;
    end else if (w_accept) begin
      r_op      <= cmd_op;
      r_operand <= cmd_operand;
      r_cin     <= cmd_cin;
      r_err     <= !cmd_load && !is_legal_op(cmd_op);
      if (cmd_load) r_acc <= cmd_operand;
    end else if (r_state == S_EXEC) begin
      r_acc   <= alu_y;
      // ASR reports sign from the result itself rather than the ALU's negative flag
      r_flags <= {(r_op == OP_ASR) ? alu_y[WIDTH-1] : alu_negative, alu_zero, alu_cout, alu_overflow};
    end else if (r_state == S_MUL && w_mul_done) begin
      r_acc   <= w_product[WIDTH-1:0];
      r_flags <= {w_product[WIDTH-1], w_product[WIDTH-1:0] == '0, w_hi, w_hi};
    end
  end
  shift_add_mul #(.WIDTH(WIDTH), .CYCLES(MUL_CYCLES)) u_mul (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_start        (w_start),
    .i_multiplicand (r_acc),
    .i_multiplier   (cmd_operand),
    .o_done         (w_mul_done),
    .o_product      (w_product)
  );
  assign cmd_ready = r_state == S_IDLE;
  assign rsp_valid = r_state == S_RESP;
  assign alu_a     = r_acc;
  assign alu_b     = r_operand;
  assign alu_sel   = r_op;
  assign alu_cin   = r_cin;
  assign rsp_data  = r_acc;
  assign rsp_flags = r_flags;
  assign rsp_err   = r_err;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed table, randomized model comparison, backpressure and mid-multiply reset.
module tb_alu_sequencer;
  logic        clk = 1'b0;
  logic        rst_n, cmd_valid, cmd_ready, cmd_cin, cmd_load;
  logic [3:0]  cmd_op, alu_sel, rsp_flags;
  logic [31:0] cmd_operand, alu_a, alu_b, alu_y, rsp_data;
  logic        alu_cin, alu_cout, alu_negative, alu_zero, alu_overflow;
  logic        rsp_valid, rsp_ready, rsp_err;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] m_acc;
  logic [3:0]  m_flags;

  typedef struct {
    logic        ld;
    logic [3:0]  op;
    logic [31:0] opd;
    logic        cin;
    int          hold;
    logic [31:0] d;
    logic [3:0]  f;
    logic        e;
    int          lat;
  } vec_t;
  vec_t tv[15];

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_operand(cmd_operand), .cmd_cin(cmd_cin), .cmd_load(cmd_load), .alu_a(alu_a), .alu_b(alu_b),
    .alu_sel(alu_sel), .alu_cin(alu_cin), .alu_y(alu_y), .alu_cout(alu_cout),
    .alu_negative(alu_negative), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .rsp_err(rsp_err)
  );

  // Stand-in ALU; its negative flag is deliberately 0 for ASR so the sequencer's override is visible
  function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] s, input logic ci);
    logic [32:0] t;
    logic [31:0] y;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    case (s)
      4'b0000: y = a & b;
      4'b0001: y = a | b;
      4'b0010: y = a ^ b;
      4'b0110: begin
        t = {1'b0, a} + {1'b0, b} + {32'd0, ci};
        y = t[31:0];
        c = t[32];
        v = (a[31] == b[31]) && (y[31] != a[31]);
      end
      4'b0111: begin
        y = a - b;
        c = a >= b;
        v = (a[31] != b[31]) && (y[31] != a[31]);
      end
      4'b1101: y = $signed(a) >>> b[4:0];
      default: y = a ^ ~b;
    endcase
    return {y, (s == 4'b1101) ? 1'b0 : y[31], y == 32'd0, c, v};
  endfunction

  always_comb {alu_y, alu_negative, alu_zero, alu_cout, alu_overflow} = alu_ref(alu_a, alu_b, alu_sel, alu_cin);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run(input logic ld, input logic [3:0] op, input logic [31:0] opd, input logic cin,
                     input int hold, input logic [31:0] e_d, input logic [3:0] e_f, input logic e_e,
                     input int e_lat);
    int lat;
    check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_load = ld; cmd_op = op; cmd_operand = opd; cmd_cin = cin; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(e_lat));
    check("rsp_data", rsp_data, e_d);
    check("rsp_flags", {28'd0, rsp_flags}, {28'd0, e_f});
    check("rsp_err", {31'd0, rsp_err}, {31'd0, e_e});
    for (int i = 0; i < hold; i++) begin
      cmd_load = 1'b1; cmd_operand = 32'hDEADBEEF; cmd_valid = 1'b1;
      @(negedge clk);
      check("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("hold_data", rsp_data, e_d);
      check("hold_flags", {28'd0, rsp_flags}, {28'd0, e_f});
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_done", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] e_d;
    logic [3:0]  e_f, op;
    logic [35:0] r;
    logic [63:0] p;
    logic        e_e, ld;
    int          e_l, seen;
    tv[0]  = '{1'b1, 4'h0, 32'd5,         1'b0, 0, 32'd5,         4'b0000, 1'b0, 1};
    tv[1]  = '{1'b0, 4'h6, 32'd3,         1'b0, 0, 32'd8,         4'b0000, 1'b0, 2};
    tv[2]  = '{1'b1, 4'h0, 32'h7FFFFFFF,  1'b0, 0, 32'h7FFFFFFF,  4'b0000, 1'b0, 1};
    tv[3]  = '{1'b0, 4'h6, 32'd1,         1'b0, 5, 32'h80000000,  4'b1001, 1'b0, 2};
    tv[4]  = '{1'b1, 4'h0, 32'h00010000,  1'b0, 0, 32'h00010000,  4'b1001, 1'b0, 1};
    tv[5]  = '{1'b0, 4'h9, 32'h00010000,  1'b0, 0, 32'd0,         4'b0111, 1'b0, 33};
    tv[6]  = '{1'b0, 4'hF, 32'd123,       1'b0, 0, 32'd0,         4'b0111, 1'b1, 1};
    tv[7]  = '{1'b1, 4'h0, 32'h80000000,  1'b0, 0, 32'h80000000,  4'b0111, 1'b0, 1};
    tv[8]  = '{1'b0, 4'hD, 32'd4,         1'b0, 0, 32'hF8000000,  4'b1000, 1'b0, 2};
    tv[9]  = '{1'b0, 4'h7, 32'hF8000000,  1'b0, 0, 32'd0,         4'b0110, 1'b0, 2};
    tv[10] = '{1'b0, 4'h6, 32'hFFFFFFFF,  1'b1, 0, 32'd0,         4'b0110, 1'b0, 2};
    tv[11] = '{1'b0, 4'hE, 32'd9,         1'b0, 0, 32'd0,         4'b0110, 1'b1, 1};
    tv[12] = '{1'b1, 4'h0, 32'd3,         1'b0, 0, 32'd3,         4'b0110, 1'b0, 1};
    tv[13] = '{1'b0, 4'h9, 32'd7,         1'b0, 0, 32'd21,        4'b0000, 1'b0, 33};
    tv[14] = '{1'b0, 4'h0, 32'h14,        1'b0, 0, 32'h14,        4'b0000, 1'b0, 2};
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_operand = 32'd0; cmd_cin = 1'b0;
    cmd_load = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_flags", {28'd0, rsp_flags}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_sel_cin", {27'd0, alu_sel, alu_cin}, 32'd0);
    foreach (tv[i])
      run(tv[i].ld, tv[i].op, tv[i].opd, tv[i].cin, tv[i].hold, tv[i].d, tv[i].f, tv[i].e, tv[i].lat);

    cmd_load = 1'b0; cmd_op = 4'h9; cmd_operand = 32'd5; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("midrst_acc", rsp_data, 32'd0);
    check("midrst_flags", {28'd0, rsp_flags}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("midrst_no_rsp", 32'(seen), 32'd0);

    m_acc = 32'd0;
    m_flags = 4'd0;
    for (int k = 0; k < 40; k++) begin
      ld = ($urandom_range(0, 3) == 0);
      op = 4'($urandom_range(0, 15));
      p = {32'd0, $urandom};
      e_d = $urandom_range(0, 1) ? p[31:0] : {28'd0, p[3:0]};
      e_e = 1'($urandom_range(0, 1));
      cmd_operand = e_d;
      cmd_cin = e_e;
      if (ld) begin
        e_f = m_flags; e_e = 1'b0; e_l = 1;
      end else if (op >= 4'd14) begin
        e_d = m_acc; e_f = m_flags; e_e = 1'b1; e_l = 1;
      end else if (op == 4'd9) begin
        p = {32'd0, m_acc} * {32'd0, cmd_operand};
        e_d = p[31:0];
        e_f = {p[31], p[31:0] == 32'd0, |p[63:32], |p[63:32]};
        e_e = 1'b0; e_l = 33;
      end else begin
        r = alu_ref(m_acc, cmd_operand, op, cmd_cin);
        e_d = r[35:4];
        e_f = {(op == 4'd13) ? r[35] : r[3], r[2:0]};
        e_e = 1'b0; e_l = 2;
      end
      run(ld, op, cmd_operand, cmd_cin, int'($urandom_range(0, 2)), e_d, e_f, e_e, e_l);
      m_acc = e_d;
      m_flags = e_f;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
